// File: rtl/fifo_instruction.sv
// fifo_instruction: fetch-to-decode instruction queue of {pc, inst} pairs with flush on redirect.
// Ports: clk, reset (async, active-low); upstream v_i/pc_i/inst_i with stall_o back-pressure;
// downstream v_o/pc_o/inst_o with stall_i; branch_i flushes; count_o occupancy; almost_full_o at >= AFULL.
// Optional FIFO_INSTRUCTION_BYPASS_EN: an empty queue passes the input word straight to the outputs.
module fifo_instruction #(
  parameter int WORD  = 32,
  parameter int ADDR  = 32,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_i,
  output logic            stall_o,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  output logic            v_o,
  input  logic            stall_i,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] pc_o,
  input  logic            branch_i,
  output logic [CW-1:0]   count_o,
  output logic            almost_full_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WORD-1:0] insts [DEPTH];
  logic [ADDR-1:0] pcs [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic has, enq, deq;
  assign has = count != '0;
  assign stall_o = count == CW'(DEPTH);
  assign count_o = count;
  assign almost_full_o = count >= CW'(AFULL);
  // Dequeue only ever pops a stored word; a bypassed word never touches the array.
  assign deq = has & ~stall_i & ~branch_i;
`ifdef FIFO_INSTRUCTION_BYPASS_EN
  logic byp;
  assign byp = ~has & ~branch_i;
  assign v_o = byp ? v_i : has;
  assign inst_o = byp ? inst_i : insts[rd];
  assign pc_o = byp ? pc_i : pcs[rd];
  // A bypassed word that decode takes this cycle is not written.
  assign enq = v_i & ~stall_o & ~branch_i & ~(byp & ~stall_i);
`else
  assign v_o = has;
  assign inst_o = insts[rd];
  assign pc_o = pcs[rd];
  assign enq = v_i & ~stall_o & ~branch_i;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        insts[i] <= '0;
        pcs[i] <= '0;
      end
    end else if (branch_i) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        insts[wr] <= inst_i;
        pcs[wr] <= pc_i;
        wr <= wr + 1'b1;
      end
      if (deq) rd <= rd + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
endmodule

// File: tb/tb_fifo_instruction.sv
// tb_fifo_instruction: directed and random stimulus against a queue-based reference model.
module tb_fifo_instruction;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 0, reset = 0;
  logic v_i = 0, stall_i = 0, branch_i = 0;
  logic [31:0] inst_i = 0, pc_i = 0;
  logic v_o, stall_o, almost_full_o;
  logic [31:0] inst_o, pc_o;
  logic [CW-1:0] count_o;
  logic [63:0] q[$];
  int errors = 0, checks = 0;
  logic acc;
  logic [31:0] p;

  fifo_instruction #(.WORD(32), .ADDR(32), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o), .inst_i(inst_i), .pc_i(pc_i),
    .v_o(v_o), .stall_i(stall_i), .inst_o(inst_o), .pc_o(pc_o), .branch_i(branch_i),
    .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  // acc reports whether upstream may move on to its next word.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic st, input logic br, output logic acc);
    logic [31:0] ins;
    logic byp, ev, enq, deq;
    int n;
    ins = $urandom;
    v_i = v; pc_i = pc; inst_i = ins; stall_i = st; branch_i = br;
    #1;
    n = q.size();
    byp = 0;
`ifdef FIFO_INSTRUCTION_BYPASS_EN
    byp = (n == 0) && !br;
`endif
    ev = byp ? v : (n != 0);
    chk("v_o", {63'd0, v_o}, {63'd0, ev});
    chk("count_o", 64'(count_o), 64'(n));
    chk("stall_o", {63'd0, stall_o}, {63'd0, n == DEPTH});
    chk("almost_full_o", {63'd0, almost_full_o}, {63'd0, n >= AFULL});
    if (ev) chk("head", {pc_o, inst_o}, byp ? {pc, ins} : q[0]);
    acc = v && (n != DEPTH) && !br;
    enq = acc && !(byp && !st);
    deq = (n != 0) && !st && !br;
    @(posedge clk);
    if (br) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (enq) q.push_back({pc, ins});
    end
    #1;
  endtask

  initial begin
    #12;
    chk("rst_v_o", {63'd0, v_o}, 64'd0);
    chk("rst_stall_o", {63'd0, stall_o}, 64'd0);
    chk("rst_count_o", 64'(count_o), 64'd0);
    chk("rst_afull", {63'd0, almost_full_o}, 64'd0);
    chk("rst_inst_o", 64'(inst_o), 64'd0);
    chk("rst_pc_o", 64'(pc_o), 64'd0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, acc);
    // Fill with decode stalled; the fifth word must be refused.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'(i * 4), 1, 0, acc);
      chk("fill_accept", {63'd0, acc}, {63'd0, i < 4});
    end
    // Drain while streaming; pc advances only when accepted, so pc_o order has no gaps.
    p = 32'h10;
    for (int i = 0; i < 12; i++) begin
      cyc(1, p, 0, 0, acc);
      if (acc) p += 4;
    end
    // Reduce to one entry, then one-in-one-out for 8 cycles.
    cyc(0, 0, 0, 1, acc);
    cyc(1, 32'h200, 1, 0, acc);
    for (int i = 0; i < 8; i++) cyc(1, 32'h204 + 32'(i * 4), 0, 0, acc);
    // Flush at count 3 with a word arriving in the same cycle.
    cyc(0, 0, 0, 1, acc);
    for (int i = 0; i < 3; i++) cyc(1, 32'h300 + 32'(i * 4), 1, 0, acc);
    cyc(1, 32'h40, 0, 1, acc);
    cyc(1, 32'h80, 0, 0, acc);
    cyc(0, 0, 0, 0, acc);
    cyc(0, 0, 0, 0, acc);
    // Empty queue cases that exercise bypass when enabled.
    cyc(1, 32'h100, 0, 0, acc);
    cyc(0, 0, 0, 0, acc);
    cyc(1, 32'h100, 1, 0, acc);
    cyc(0, 0, 0, 0, acc);
    cyc(0, 0, 0, 0, acc);
    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 19) == 0), acc);
    // Asynchronous reset mid-operation clears state without an edge.
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(i * 4), 1, 0, acc);
    v_i = 0;
    reset = 0;
    #1;
    chk("async_count_o", 64'(count_o), 64'd0);
    chk("async_v_o", {63'd0, v_o}, 64'd0);
    chk("async_pc_o", 64'(pc_o), 64'd0);
    q.delete();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) cyc(1, 32'h600 + 32'(i * 4), 0, 0, acc);
    cyc(0, 0, 0, 0, acc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_instruction.md
# fifo_instruction

Parametrised instruction fetch queue for the fetch stage, sitting between the instruction memory read port and decode. A DEPTH-entry circular buffer holds {pc, inst} pairs. It accepts one fetched word per cycle, presents the oldest word to decode, and empties itself on a branch redirect. It also reports occupancy and an almost-full watermark so the fetch PC logic can throttle before the queue stalls.

## Interface
Parameters:
- WORD, 32: instruction width in bits.
- ADDR, 32: PC width in bits.
- DEPTH, 4: number of entries; must be a power of two, ≥ 2.
- AFULL, DEPTH-1: almost-full threshold on occupancy, range 1..DEPTH.
- CW, $clog2(DEPTH+1): width of count_o (derived; not overridden).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- v_i, input, 1: inst_i/pc_i carry a valid fetched word.
- stall_o, output, 1: queue full; the upstream word is not accepted this cycle.
- inst_i, input, WORD: fetched instruction.
- pc_i, input, ADDR: PC of inst_i.
- v_o, output, 1: inst_o/pc_o hold a valid word.
- stall_i, input, 1: decode cannot take the word this cycle.
- inst_o, output, WORD: oldest queued instruction.
- pc_o, output, ADDR: PC of inst_o.
- branch_i, input, 1: redirect; flush all contents.
- count_o, output, CW: number of valid entries, 0..DEPTH.
- almost_full_o, output, 1: count_o ≥ AFULL.

## Operation
- Storage: DEPTH × (ADDR+WORD) registers; head pointer (rd), tail pointer (wr), occupancy counter. Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Enqueue: enq = v_i & ~stall_o & ~branch_i. Write {pc_i, inst_i} at wr, then wr+1.
- Dequeue: deq = v_o & ~stall_i & ~branch_i. Advance rd by 1.
- Count update: count += enq − deq. Simultaneous enq and deq leaves count unchanged. This is legal at any occupancy where both are permitted, including count==DEPTH−1 and count==1.
- stall_o = (count == DEPTH). It is a pure function of state, with no combinational path from stall_i. A full queue does not accept a word even when it dequeues in the same cycle.
- v_o = (count != 0). inst_o/pc_o = entry[rd], driven straight from the register array.
- Flush: branch_i has priority over everything. rd, wr and count go to 0 on the next edge. v_i and the head dequeue in that cycle are both dropped. Storage contents are not cleared.
- v_i while stall_o=1: the word is ignored. Upstream must hold it.
- Reset: all pointers, counters and storage go to 0. Outputs after reset: v_o=0, stall_o=0, count_o=0, almost_full_o=0, inst_o=0, pc_o=0.

## Timing
- Latency without bypass: a word enqueued at edge N is visible on v_o/inst_o after edge N, so decode can take it in cycle N+1.
- Throughput: 1 word/cycle in and out concurrently.
- stall_o, count_o and almost_full_o are registered-state functions, valid early in the cycle.
- After branch_i at edge N: v_o=0 and count_o=0 in cycle N+1. A v_i in cycle N+1 is accepted normally.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- Macro: FIFO_INSTRUCTION_BYPASS_EN.
- Defined: when count==0 and branch_i=0:
  - v_o=v_i, inst_o=inst_i, pc_o=pc_i combinationally.
  - If stall_i=0, the word is consumed directly and not written; count stays 0.
  - If stall_i=1, the word is enqueued normally.
  - This gives zero-cycle latency when empty.
- Undefined: no combinational input→output path; minimum latency is 1 cycle as above.

## Test plan
- Reset, then idle: v_o=0, stall_o=0, count_o=0, inst_o=0, pc_o=0.
- DEPTH=4 fill with stall_i=1: v_i=1 for 5 cycles with pc 0x00, 0x04, 0x08, 0x0C, 0x10.
  - count_o steps 1, 2, 3, 4.
  - almost_full_o=1 from count 3.
  - stall_o=1 at count 4; 0x10 is not accepted.
- Drain and wrap: continue from the full queue with stall_i=0 and v_i=1 streaming 0x10, 0x14, ...
  - First cycle: stall_o=1, so 0x10 is held upstream.
  - From the second cycle: one in, one out, count_o stays 4 → 3.
  - pc_o sequence is 0x00, 0x04, 0x08, 0x0C, 0x10, ... in order with no gaps across pointer wrap.
- Simultaneous enq/deq at count 1 over 8 cycles: count_o stays 1 and pc_o follows input delayed by one cycle.
- Flush: with count 3, assert branch_i together with v_i=1 (pc 0x40) and stall_i=0.
  - Next cycle: v_o=0, count_o=0.
  - 0x40 is absent; a following v_i (pc 0x80) appears on pc_o one cycle later.
- Bypass (macro defined), empty queue:
  - v_i=1, pc 0x100, stall_i=0 → v_o=1, pc_o=0x100 the same cycle, count_o stays 0.
  - Repeat with stall_i=1 → count_o=1 next cycle.
